// File: rtl/high_pass_filter.sv
// Pan-Tompkins high-pass stage: y(n) = x(n-16) - floor(p(n)/32), where p(n) is the
// running sum of the last 32 inputs. Output is registered and valid-qualified.
module high_pass_filter #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned ACC_WIDTH  = DATA_WIDTH + 5,
  parameter int unsigned OUT_WIDTH  = DATA_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  settled
);

  localparam int unsigned DEPTH = 32;
  localparam int unsigned PTR_W = 5;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned SHIFT = 5;
  localparam int unsigned EXT_W = ACC_WIDTH - DATA_WIDTH;

  logic [DATA_WIDTH-1:0]        r_buf [DEPTH];
  logic [PTR_W-1:0]             r_wptr;
  logic [CNT_W-1:0]             r_count;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_out_valid;
  logic signed [OUT_WIDTH-1:0]  r_out_data;
  logic                         r_settled;

  logic                         w_accept;
  logic [DATA_WIDTH-1:0]        w_oldest;
  logic [DATA_WIDTH-1:0]        w_mid;
  logic signed [ACC_WIDTH-1:0]  w_x_ext;
  logic signed [ACC_WIDTH-1:0]  w_old_ext;
  logic signed [ACC_WIDTH-1:0]  w_mid_ext;
  logic signed [ACC_WIDTH-1:0]  w_acc_next;
  logic signed [ACC_WIDTH-1:0]  w_shift;
  logic signed [OUT_WIDTH-1:0]  w_y;
  logic [CNT_W-1:0]             w_count_next;

  assign w_accept = en & in_valid;

  // x(n-32) sits at the write pointer, x(n-16) half the ring away.
  assign w_oldest = r_buf[r_wptr];
  assign w_mid    = r_buf[r_wptr ^ PTR_W'(DEPTH / 2)];

  assign w_x_ext   = {{EXT_W{in_data[DATA_WIDTH-1]}}, in_data};
  assign w_old_ext = {{EXT_W{w_oldest[DATA_WIDTH-1]}}, w_oldest};
  assign w_mid_ext = {{EXT_W{w_mid[DATA_WIDTH-1]}}, w_mid};

  // p is the exact 32-sample sum, so the accumulator never wraps.
  assign w_acc_next = r_acc + w_x_ext - w_old_ext;
  assign w_shift    = w_acc_next >>> SHIFT;
  // |y| <= 2^DATA_WIDTH, so dropping the accumulator's upper bits is lossless.
  assign w_y        = OUT_WIDTH'(w_mid_ext - w_shift);

  assign w_count_next = (r_count == CNT_W'(DEPTH)) ? r_count : r_count + CNT_W'(1);

  // Sample acceptance, delay line, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_wptr      <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_settled   <= 1'b0;
    end else if (w_accept) begin
      r_buf[r_wptr] <= in_data;
      r_wptr        <= r_wptr + PTR_W'(1);
      r_acc         <= w_acc_next;
      r_count       <= w_count_next;
      r_out_data    <= w_y;
      r_out_valid   <= 1'b1;
      r_settled     <= (w_count_next == CNT_W'(DEPTH));
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign settled   = r_settled;

endmodule

// File: tb/tb_high_pass_filter.sv
// Directed-vector bench for high_pass_filter: a table of per-cycle stimulus with
// hand-derived expected outputs, replayed and compared one cycle after each edge.
module tb_high_pass_filter;

  localparam int unsigned DW = 11;
  localparam int unsigned OW = 12;

  logic          clk = 1'b0;
  logic          rstn;
  logic          en;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          settled;

  high_pass_filter #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .settled   (settled)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  rstn;
    logic  en;
    logic  vld;
    int    data;
    logic  exp_valid;
    int    exp_data;
    logic  exp_settled;
    string tag;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   last_y = 0;
  logic last_s = 1'b0;

  // Expected y(n) for an input that is a constant x from n=0.
  function automatic int dc_y(int x, int n);
    int p, mid;
    p   = x * ((n + 1 < 32) ? n + 1 : 32);
    mid = (n >= 16) ? x : 0;
    return mid - (p >>> 5);
  endfunction

  // Expected y(n) for a single sample a at n=0 followed by zeros.
  function automatic int imp_y(int a, int n);
    int p, mid;
    p   = (n < 32) ? a : 0;
    mid = (n == 16) ? a : 0;
    return mid - (p >>> 5);
  endfunction

  task automatic add(logic r, logic e, logic v, int d, logic ev, int ed, logic es, string tag);
    vec_t t;
    t.rstn = r; t.en = e; t.vld = v; t.data = d;
    t.exp_valid = ev; t.exp_data = ed; t.exp_settled = es; t.tag = tag;
    vecs.push_back(t);
  endtask

  task automatic acc(int d, int y, int n, string tag);
    last_y = y;
    last_s = (n >= 31);
    add(1'b1, 1'b1, 1'b1, d, 1'b1, y, last_s, tag);
  endtask

  task automatic gap(logic e, logic v, int d, string tag);
    add(1'b1, e, v, d, 1'b0, last_y, last_s, tag);
  endtask

  task automatic rst(int d, string tag);
    last_y = 0;
    last_s = 1'b0;
    add(1'b0, 1'b1, 1'b1, d, 1'b0, 0, 1'b0, tag);
  endtask

  task automatic check(string name, int idx, int got, int exp);
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, got, exp);
    end
  endtask

  initial begin
    // Reset held with a live input, then the first accept after release.
    for (int i = 0; i < 3; i++) rst(500, "reset");
    acc(500, -15, 0, "first");

    rst(0, "reset");
    for (int n = 0; n <= 40; n++) acc((n == 0) ? 100 : 0, imp_y(100, n), n, "impulse");

    rst(0, "reset");
    for (int n = 0; n <= 40; n++) acc(320, dc_y(320, n), n, "dc320");

    rst(0, "reset");
    for (int n = 0; n < 40; n++) acc(1023, dc_y(1023, n), n, "dc1023");

    rst(0, "reset");
    for (int n = 0; n < 4; n++) acc((n == 0) ? -1 : 0, imp_y(-1, n), n, "neg1");

    rst(0, "reset");
    for (int n = 0; n < 36; n++) acc(-64, dc_y(-64, n), n, "dcm64");

    // Impulse with valid gaps and an enable drop whose samples must be discarded.
    rst(0, "reset");
    for (int n = 0; n <= 40; n++) begin
      if (n == 10) for (int k = 0; k < 5; k++) gap(1'b0, 1'b1, 555, "stall_en");
      else if (n % 3 == 1) gap(1'b1, 1'b0, 777, "stall_vld");
      acc((n == 0) ? 100 : 0, imp_y(100, n), n, "stall");
    end

    // Reset in the middle of a DC run must leave no residue.
    rst(0, "reset");
    for (int n = 0; n <= 20; n++) acc(320, dc_y(320, n), n, "pre_rst");
    rst(320, "mid_rst");
    for (int n = 0; n <= 35; n++) acc(320, dc_y(320, n), n, "post_rst");

    for (int i = 0; i < vecs.size(); i++) begin
      rstn     = vecs[i].rstn;
      en       = vecs[i].en;
      in_valid = vecs[i].vld;
      in_data  = DW'(vecs[i].data);
      @(posedge clk);
      #1;
      n_vec++;
      check({vecs[i].tag, ".valid"},   i, int'(out_valid), int'(vecs[i].exp_valid));
      check({vecs[i].tag, ".data"},    i, int'($signed(out_data)), vecs[i].exp_data);
      check({vecs[i].tag, ".settled"}, i, int'(settled), int'(vecs[i].exp_settled));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/high_pass_filter.md
Name: high_pass_filter

Overview:
Second stage of the Pan-Tompkins QRS front end. It sits directly downstream of the low-pass filter and consumes its signed sample stream. It implements the integer high-pass filter y(n) = x(n-16) - floor(p(n)/32), with running sum p(n) = p(n-1) + x(n) - x(n-32). It feeds the derivative stage with a registered, valid-qualified output.

Parameters:
DATA_WIDTH, 11, width of the signed two's-complement input sample
ACC_WIDTH, DATA_WIDTH+5, width of the signed running-sum accumulator p; must be >= DATA_WIDTH+5
OUT_WIDTH, DATA_WIDTH+1, width of the signed output sample

Ports:
clk  in  1  clock; all state updates on the rising edge
rstn  in  1  synchronous reset, active-low
en  in  1  stage enable; when low, all state holds
in_valid  in  1  in_data carries a new sample this cycle
in_data  in  DATA_WIDTH  signed input sample x(n) from the low-pass filter
out_valid  out  1  one-cycle pulse; out_data holds a new y(n)
out_data  out  OUT_WIDTH  signed filtered sample y(n)
settled  out  1  high once 32 samples have been accepted since reset (delay line full)

Behaviour:
- Reset (rstn=0 at a clock edge) clears the following; rstn takes priority over en and in_valid:
  - all 32 delay-line entries to 0
  - write pointer wptr (5 bit) to 0
  - accumulator p to 0
  - sample counter to 0
  - out_valid=0, out_data=0, settled=0
- Accept condition: rstn=1, en=1 and in_valid=1 at a rising edge. There is no backpressure; every accepted sample produces exactly one output.
- Delay line: 32-entry circular buffer buf[0..31]. Before an accept, buf[wptr] holds x(n-32) and buf[wptr^16] holds x(n-16).
- On accept, all of the following update in the same edge:
  - p <= p + sext(in_data) - sext(buf[wptr])
  - out_data <= sext(buf[wptr^16]) - (p_next >>> 5), where p_next is the new p value and >>> is an arithmetic shift (floor toward -inf)
  - buf[wptr] <= in_data
  - wptr <= wptr+1 (wraps 31->0)
  - counter <= min(counter+1, 32)
  - out_valid <= 1
- Latency: one cycle. A sample accepted at edge k gives out_valid=1 and its y(n) during the cycle after edge k.
- No accept (en=0 or in_valid=0): out_valid <= 0. out_data, p, wptr, buf and counter all hold.
- settled: registered, equals (counter==32). It goes high in the same cycle as the 32nd sample's out_valid.
- Warm-up: before settled, the empty entries read as 0, so outputs follow the same equations with x(n-k)=0 for k>n. These outputs are still flagged out_valid.
- Widths:
  - p exactly equals the sum of the last 32 inputs, so it cannot overflow ACC_WIDTH.
  - |y| <= 2^DATA_WIDTH, which fits OUT_WIDTH; no saturation logic is required.
- Reset mid-stream: the next accepted sample behaves as n=0. No residue from earlier samples is allowed.
- in_valid asserted with en=0: the sample is dropped, not queued.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with in_valid=1, in_data=500 -> out_valid=0, out_data=0, settled=0 throughout. After release, the first accept gives y=-15 (x=500: p=500, 500>>>5=15).
- Impulse: x=100 at n=0, then 0 for n=1..40, in_valid continuous. Required out_data:
  - n=0..15: -3
  - n=16: 97
  - n=17..31: -3
  - n=32..40: 0
  - settled rises with n=31's output.
- DC step: constant x=320. Required out_data:
  - n=0: -10
  - n=15: -160
  - n=16: 150
  - n=31: 0
  - n>=31: 0
  Constant x=1023 for 40 samples: p peaks at 32736 with no overflow, and y settles to 0.
- Negative rounding: single x=-1 then zeros -> y(0)=+1 (floor(-1/32)=-1). Constant x=-64 -> y(0)=+2, and y(n>=31)=0.
- Stall: impulse test with in_valid toggled 1-0-1 and en dropped for 5 cycles at n=10. Output values are identical to the unstalled run. out_valid pulses only after accepts. out_data holds during gaps.
- Mid-stream reset: run the DC 320 test to n=20, pulse rstn=0 for 1 cycle, resume with constant 320 -> outputs repeat the sequence from n=0 (-10, ...). settled is low until 32 new samples have been accepted.
